// File: rtl/bram_stream_reader_if.sv
// Bundles the command, BRAM read-port and stream-out signals of bram_stream_reader.
// The master modport is the reader itself; the slave modport is whatever surrounds it.
interface bram_stream_reader_if #(
    parameter int WIDTH     = 72,
    parameter int LOG_DEPTH = 9
);
    logic [LOG_DEPTH-1:0] cmd_addr;
    logic [LOG_DEPTH:0]   cmd_len;
    logic                 cmd_valid;
    logic                 cmd_ready;

    logic [LOG_DEPTH-1:0] bram_addr;
    logic                 bram_en;
    logic [WIDTH-1:0]     bram_rdata;

    logic [WIDTH-1:0]     ms_data;
    logic                 ms_valid;
    logic                 ms_ready;
    logic                 ms_last;
    logic                 busy;

    modport master (
        input  cmd_addr, cmd_len, cmd_valid, bram_rdata, ms_ready,
        output cmd_ready, bram_addr, bram_en, ms_data, ms_valid, ms_last, busy
    );

    modport slave (
        output cmd_addr, cmd_len, cmd_valid, bram_rdata, ms_ready,
        input  cmd_ready, bram_addr, bram_en, ms_data, ms_valid, ms_last, busy
    );
endinterface

// File: rtl/bram_stream_reader.sv
// Drains a burst of words from a synchronous-read BRAM onto a valid/ready stream,
// hiding the 1-cycle read latency with a 2-entry buffer plus a bypass of the in-flight word.
module bram_stream_reader #(
    parameter int WIDTH     = 72,
    parameter int DEPTH     = 512,
    parameter int LOG_DEPTH = 9
) (
    input  logic                  clk,
    input  logic                  resetn,
    bram_stream_reader_if.master  bus
);
    if (DEPTH != (1 << LOG_DEPTH)) begin : g_depth_check
        $error("DEPTH must equal 2**LOG_DEPTH");
    end

    typedef enum logic {S_IDLE, S_RUN} state_e;

    localparam logic [LOG_DEPTH:0] CNT_ONE = {{LOG_DEPTH{1'b0}}, 1'b1};

    state_e               r_state;
    state_e               w_state_next;

    logic [LOG_DEPTH-1:0] r_start;
    logic [LOG_DEPTH:0]   r_len;
    logic [LOG_DEPTH:0]   r_issued;
    logic [LOG_DEPTH:0]   r_accepted;
    logic                 r_in_flight;
    logic [WIDTH-1:0]     r_buf [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;

    logic                 w_cmd_fire;
    logic                 w_start_burst;
    logic                 w_ms_valid;
    logic                 w_pop;
    logic                 w_last_word;
    logic [2:0]           w_occupancy;
    logic                 w_bram_en;
    logic [WIDTH-1:0]     w_head;

    assign w_cmd_fire    = bus.cmd_valid && (r_state == S_IDLE);
    assign w_start_burst = w_cmd_fire && (bus.cmd_len != '0);

    // With the buffer empty, the word arriving from the BRAM this cycle is the head.
    assign w_ms_valid  = (r_count != 2'd0) || r_in_flight;
    assign w_head      = (r_count != 2'd0) ? r_buf[r_rd_ptr] : bus.bram_rdata;
    assign w_pop       = w_ms_valid && bus.ms_ready;
    assign w_last_word = (r_accepted == (r_len - CNT_ONE));

    // Space left after this cycle's capture and pop decides whether another read fits.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_in_flight};
    assign w_bram_en   = (r_state == S_RUN) && (r_issued < r_len)
                       && (w_occupancy < (3'd2 + {2'b00, w_pop}));

    // NOTE: state and counters update with non-blocking assignments so every
    // process samples the pre-edge values; combinational blocks use blocking.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_burst) w_state_next = S_RUN;
            S_RUN:   if (w_pop && w_last_word) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b0;
        bus.bram_en   = w_bram_en;
        bus.bram_addr = r_start + r_issued[LOG_DEPTH-1:0];
        bus.ms_valid  = w_ms_valid;
        bus.ms_last   = w_ms_valid && w_last_word;
        bus.ms_data   = w_ms_valid ? w_head : '0;
        case (r_state)
            S_IDLE:  bus.cmd_ready = 1'b1;
            S_RUN:   bus.busy      = 1'b1;
            default: bus.cmd_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_start     <= '0;
            r_len       <= '0;
            r_issued    <= '0;
            r_accepted  <= '0;
            r_in_flight <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            if (w_start_burst) begin
                r_start    <= bus.cmd_addr;
                r_len      <= bus.cmd_len;
                r_issued   <= '0;
                r_accepted <= '0;
            end else begin
                if (w_bram_en) r_issued   <= r_issued + CNT_ONE;
                if (w_pop)     r_accepted <= r_accepted + CNT_ONE;
            end
            r_in_flight <= w_bram_en;
            if (r_in_flight) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)       r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, r_in_flight} - {1'b0, w_pop};
        end
    end

    // NOTE: the data storage has no reset; clearing the count and pointers empties it,
    // and ms_data is forced to zero whenever nothing valid is presented.
    always_ff @(posedge clk) begin
        if (r_in_flight) r_buf[r_wr_ptr] <= bus.bram_rdata;
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: a BRAM model returning each word's own address,
// one task per scenario with hand-computed expectations.
module tb_bram_stream_reader;
    localparam int WIDTH     = 72;
    localparam int DEPTH     = 512;
    localparam int LOG_DEPTH = 9;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    bram_stream_reader_if #(.WIDTH(WIDTH), .LOG_DEPTH(LOG_DEPTH)) bus ();

    bram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // BRAM model: word content equals its address, available one cycle after the strobe.
    always @(posedge clk) begin
        if (bus.bram_en) bus.bram_rdata <= {{(WIDTH-LOG_DEPTH){1'b0}}, bus.bram_addr};
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [WIDTH-1:0] got_data[$];
    bit               got_last[$];
    int               en_cnt;
    int               unstable;
    int               first_cyc;
    int               done_cyc;
    bit               done;

    // Called at posedge+1; returns at posedge+1 of the first cycle after the handshake.
    task automatic send_cmd(input logic [LOG_DEPTH-1:0] a, input logic [LOG_DEPTH:0] l,
                            output bit ok);
        ok = 1'b0;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Cycle 0 is the first cycle after the command handshake.
    task automatic collect(input int max_cyc, input bit use_pat, input logic [31:0] pat);
        bit               held;
        logic [WIDTH-1:0] held_data;
        bit               held_last;
        got_data.delete();
        got_last.delete();
        en_cnt    = 0;
        unstable  = 0;
        first_cyc = -1;
        done_cyc  = -1;
        done      = 1'b0;
        held      = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            bus.ms_ready = use_pat ? pat[c % 32] : 1'b1;
            @(negedge clk);
            if (bus.bram_en) en_cnt++;
            if (bus.ms_valid && first_cyc < 0) first_cyc = c;
            if (held && (!bus.ms_valid || bus.ms_data !== held_data || bus.ms_last !== held_last))
                unstable++;
            held      = bus.ms_valid && !bus.ms_ready;
            held_data = bus.ms_data;
            held_last = bus.ms_last;
            if (bus.ms_valid && bus.ms_ready) begin
                got_data.push_back(bus.ms_data);
                got_last.push_back(bus.ms_last);
                if (bus.ms_last) begin
                    done     = 1'b1;
                    done_cyc = c;
                end
            end
            @(posedge clk); #1;
            if (done) break;
        end
        bus.ms_ready = 1'b1;
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.ms_ready  = 1'b0;
        resetn        = 1'b0;
        #12;
        total_cnt++;
        if ({bus.cmd_ready, bus.bram_en, bus.bram_addr, bus.ms_valid, bus.ms_last, bus.busy} !== {1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0}
            || bus.ms_data !== '0)
            $display("FAIL reset_outputs: rdy=%b en=%b addr=%0d vld=%b last=%b busy=%b data=%0h, want 1 0 0 0 0 0 0",
                     bus.cmd_ready, bus.bram_en, bus.bram_addr, bus.ms_valid, bus.ms_last, bus.busy, bus.ms_data);
        else pass_cnt++;
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({bus.cmd_ready, bus.ms_valid, bus.bram_en, bus.busy} !== 4'b1000)
                $display("FAIL idle_cycle%0d: {rdy,vld,en,busy}=%b want 1000", c,
                         {bus.cmd_ready, bus.ms_valid, bus.bram_en, bus.busy});
            else pass_cnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_timing();
        bit ok;
        bus.ms_ready = 1'b1;
        send_cmd(9'd10, 10'd4, ok);
        total_cnt++;
        if (!ok) $display("FAIL basic_cmd_accept: cmd_ready never seen");
        else pass_cnt++;
        for (int c = 0; c < 6; c++) begin
            bit               exp_en    = (c <= 3);
            bit               exp_valid = (c >= 1 && c <= 4);
            logic [8:0]       exp_addr  = 9'(10 + c);
            logic [WIDTH-1:0] exp_data  = exp_valid ? WIDTH'(9 + c) : '0;
            bit               exp_last  = (c == 4);
            bit               exp_busy  = (c <= 4);
            @(negedge clk);
            total_cnt++;
            if (bus.bram_en !== exp_en || (exp_en && bus.bram_addr !== exp_addr))
                $display("FAIL basic_read_c%0d: en=%b addr=%0d want en=%b addr=%0d",
                         c, bus.bram_en, bus.bram_addr, exp_en, exp_addr);
            else pass_cnt++;
            total_cnt++;
            if (bus.ms_valid !== exp_valid || bus.ms_data !== exp_data || bus.ms_last !== exp_last)
                $display("FAIL basic_stream_c%0d: vld=%b data=%0d last=%b want vld=%b data=%0d last=%b",
                         c, bus.ms_valid, bus.ms_data, bus.ms_last, exp_valid, exp_data, exp_last);
            else pass_cnt++;
            total_cnt++;
            if (bus.busy !== exp_busy || bus.cmd_ready !== !exp_busy)
                $display("FAIL basic_busy_c%0d: busy=%b rdy=%b want busy=%b rdy=%b",
                         c, bus.busy, bus.cmd_ready, exp_busy, !exp_busy);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap_stall();
        bit         ok;
        int         bad;
        logic [8:0] a;
        send_cmd(9'd508, 10'd6, ok);
        collect(200, 1'b1, 32'b1011_0110_0101_1001_1000_1101_0011_1001);
        total_cnt++;
        if (!ok || !done || got_data.size() != 6)
            $display("FAIL stall_count: ok=%b done=%b words=%0d want 1 1 6", ok, done, got_data.size());
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < got_data.size() && i < 6; i++) begin
            a = 9'(508 + i);
            if (got_data[i] !== WIDTH'(a) || got_last[i] !== (i == 5)) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL stall_order: %0d bad words, want 508,509,510,511,0,1", bad);
        else pass_cnt++;
        total_cnt++;
        if (unstable != 0) $display("FAIL stall_stable: %0d unstable stall cycles want 0", unstable);
        else pass_cnt++;
        total_cnt++;
        if (en_cnt != 6) $display("FAIL stall_reads: %0d read strobes want 6", en_cnt);
        else pass_cnt++;
    endtask

    task automatic test_len_zero();
        bit ok;
        send_cmd(9'd20, 10'd0, ok);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({bus.cmd_ready, bus.busy, bus.ms_valid, bus.bram_en} !== 4'b1000)
                $display("FAIL len0_idle_c%0d: {rdy,busy,vld,en}=%b want 1000", c,
                         {bus.cmd_ready, bus.busy, bus.ms_valid, bus.bram_en});
            else pass_cnt++;
            @(posedge clk); #1;
        end
        send_cmd(9'd5, 10'd1, ok);
        collect(20, 1'b0, 32'h0);
        total_cnt++;
        if (!ok || got_data.size() != 1 || got_data[0] !== WIDTH'(5) || got_last[0] !== 1'b1)
            $display("FAIL len1_word: ok=%b words=%0d data=%0d last=%b want 1 1 5 1", ok, got_data.size(),
                     (got_data.size() > 0) ? got_data[0] : '0, (got_data.size() > 0) ? got_last[0] : 1'b0);
        else pass_cnt++;
        total_cnt++;
        if (first_cyc != 1 || en_cnt != 1)
            $display("FAIL len1_timing: first_valid=%0d reads=%0d want 1 1", first_cyc, en_cnt);
        else pass_cnt++;
    endtask

    task automatic test_full_depth();
        bit ok;
        int bad_data;
        int bad_last;
        send_cmd(9'd0, 10'd512, ok);
        collect(700, 1'b0, 32'h0);
        total_cnt++;
        if (!ok || got_data.size() != 512)
            $display("FAIL full_count: ok=%b words=%0d want 1 512", ok, got_data.size());
        else pass_cnt++;
        bad_data = 0;
        bad_last = 0;
        for (int i = 0; i < got_data.size(); i++) begin
            if (got_data[i] !== WIDTH'(i)) bad_data++;
            if (got_last[i] !== (i == 511)) bad_last++;
        end
        total_cnt++;
        if (bad_data != 0) $display("FAIL full_data: %0d words differ from 0..511", bad_data);
        else pass_cnt++;
        total_cnt++;
        if (bad_last != 0) $display("FAIL full_last: %0d misplaced last flags want 0", bad_last);
        else pass_cnt++;
        total_cnt++;
        if (first_cyc != 1 || done_cyc != 512 || en_cnt != 512)
            $display("FAIL full_rate: first=%0d last=%0d reads=%0d want 1 512 512", first_cyc, done_cyc, en_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        int hs;
        bus.ms_ready = 1'b1;
        send_cmd(9'd200, 10'd8, ok);
        hs = 0;
        for (int c = 0; c < 20 && hs < 3; c++) begin
            @(negedge clk);
            if (bus.ms_valid && bus.ms_ready) hs++;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (hs != 3 || bus.ms_valid !== 1'b1 || bus.busy !== 1'b1)
            $display("FAIL midrst_pre: hs=%0d vld=%b busy=%b want 3 1 1", hs, bus.ms_valid, bus.busy);
        else pass_cnt++;
        #2;
        resetn = 1'b0;
        #1;
        total_cnt++;
        if ({bus.cmd_ready, bus.bram_en, bus.bram_addr, bus.ms_valid, bus.ms_last, bus.busy} !== {1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0}
            || bus.ms_data !== '0)
            $display("FAIL midrst_async: rdy=%b en=%b addr=%0d vld=%b last=%b busy=%b data=%0h want 1 0 0 0 0 0 0",
                     bus.cmd_ready, bus.bram_en, bus.bram_addr, bus.ms_valid, bus.ms_last, bus.busy, bus.ms_data);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        send_cmd(9'd100, 10'd2, ok);
        collect(20, 1'b0, 32'h0);
        total_cnt++;
        if (!ok || got_data.size() != 2 || got_data[0] !== WIDTH'(100) || got_data[1] !== WIDTH'(101)
            || got_last[0] !== 1'b0 || got_last[1] !== 1'b1)
            $display("FAIL midrst_after: ok=%b words=%0d want exactly 100,101 with last on 101", ok, got_data.size());
        else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if (bus.ms_valid !== 1'b0 || bus.cmd_ready !== 1'b1)
                $display("FAIL midrst_tail_c%0d: vld=%b rdy=%b want 0 1", c, bus.ms_valid, bus.cmd_ready);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic_timing();
        test_wrap_stall();
        test_len_zero();
        test_full_depth();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Reader counterpart to the BRAM FIFO write path: drains a region of a synchronous-read dual-port BRAM onto a valid/ready master stream.
- A command (start address, word count) starts a burst.
- Hides the 1-cycle BRAM read latency with a 2-entry output buffer, so a burst sustains 1 word/cycle when the sink never stalls.
- Sits between the accelerator result BRAM and the DMA/stream-out side of the wrapper.

Parameters:
- WIDTH, 72, data word width (matches BRAM word).
- DEPTH, 512, BRAM words; power of two.
- LOG_DEPTH, 9, log2(DEPTH); address width.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- cmd_addr  in  LOG_DEPTH  first BRAM address of the burst.
- cmd_len  in  LOG_DEPTH+1  word count, 0..DEPTH.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accept; high only in IDLE.
- bram_addr  out  LOG_DEPTH  BRAM read address.
- bram_en  out  1  read strobe; bram_rdata is valid exactly 1 cycle after bram_en=1.
- bram_rdata  in  WIDTH  BRAM read data.
- ms_data  out  WIDTH  stream data.
- ms_valid  out  1  stream valid.
- ms_ready  in  1  stream ready from the sink.
- ms_last  out  1  marks the final word of the burst; qualified by ms_valid.
- busy  out  1  high from command accept until the last word is accepted.

Behaviour:
- Reset: asynchronous, active-low; takes effect immediately, independent of clk.
  - Outputs during and after reset: cmd_ready=1, bram_en=0, bram_addr=0, ms_valid=0, ms_last=0, ms_data=0, busy=0.
  - Reset flushes the output buffer, clears counters, and discards any in-flight read, including when asserted mid-burst.
- States:
  - IDLE: cmd_ready=1. A handshake with cmd_len>0 latches addr/len and goes to RUN. A handshake with cmd_len=0 is consumed and ignored; the block stays in IDLE with no stream output.
  - RUN: issues reads and emits words. Goes to IDLE on the cycle the last word is accepted by the sink (ms_valid && ms_ready && ms_last).
- Read issue rule: bram_en=1 in a cycle iff all of the following hold:
  - state is RUN;
  - issued < len;
  - occupancy + in_flight − (ms_valid && ms_ready this cycle) < 2, where occupancy is the number of buffered words (0..2) and in_flight is 1 if a read was issued last cycle.
- Buffer can never overflow; the rule above is the only read gate.
- Address: bram_addr = start + issued, wrapping modulo DEPTH (511 → 0).
- Data capture: bram_rdata is written into the buffer the cycle after bram_en, unconditionally.
- Stream output:
  - ms_data, ms_valid and ms_last are driven from the buffer head.
  - Once ms_valid=1, ms_data and ms_last stay stable until ms_valid && ms_ready.
  - Word order equals address order.
- Latency and throughput:
  - Command handshake at cycle N → first bram_en at cycle N+1 → ms_valid=1 at cycle N+2.
  - With ms_ready held at 1, ms_valid stays 1 for len consecutive cycles.
- ms_last=1 only with the word whose index is len−1. A len=1 burst yields a single word with ms_last=1.
- busy=1 from the cycle after command accept through the cycle of the last handshake. cmd_ready returns to 1 the following cycle.
- Back-to-back commands: not overlapped; minimum 1 idle cycle between bursts.
- cmd_len=DEPTH reads the full memory once, wrapping back to start, without repeating any word.
- Widths: issued/accepted counters are LOG_DEPTH+1 bits wide. Address arithmetic is LOG_DEPTH bits and truncates.

Test Plan:
- Reset then idle → cmd_ready=1, ms_valid=0, bram_en=0, busy=0 for 10 cycles.
- cmd addr=10 len=4, ms_ready=1 constant, BRAM word = address → handshake at cycle 0; bram_addr 10..13 on cycles 1..4; ms_data 10,11,12,13 on cycles 2..5; ms_last only on 13; cmd_ready=1 at cycle 6.
- cmd addr=508 len=6 with random ms_ready stalls → data 508,509,510,511,0,1 in order; no drop or duplicate; ms_data stable during every stall; buffer never exceeds 2 entries.
- len=0 command, then len=1 addr=5 → no output for the first command; the second produces a single word 5 with ms_last=1.
- len=512 addr=0, ms_ready=1 → 512 consecutive valid cycles, data 0..511, ms_last on 511 only.
- resetn asserted asynchronously mid-burst (after 3 of 8 words) → outputs go to reset values immediately; after release, a new cmd addr=100 len=2 yields exactly 100,101.
